// File: rtl/hippo_irq_sched.sv
// Nested priority interrupt scheduler: arbitrates pending lines, drives the
// RegFileStack push/pop commands and redirects the core PC on entry and exit.
module hippo_irq_sched #(
    parameter int NumIrq    = 8,
    parameter int PrioWidth = 3,
    parameter int Depth     = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NumIrq-1:0]          irq_i,
    input  logic                       prio_we_i,
    input  logic [$clog2(NumIrq)-1:0]  prio_idx_i,
    input  logic [PrioWidth-1:0]       prio_data_i,
    input  logic [31:0]                vec_base_i,
    input  logic [31:0]                pc_next_i,
    input  logic                       mret_i,
    output logic                       stall_o,
    output logic                       push_o,
    output logic                       pop_o,
    output logic                       redirect_o,
    output logic [31:0]                target_o,
    output logic [$clog2(Depth+1)-1:0] depth_o,
    output logic [PrioWidth-1:0]       cur_prio_o,
    output logic                       err_o
);

    localparam int IdxW = $clog2(NumIrq);
    localparam int DepW = $clog2(Depth + 1);
    localparam int StkW = (Depth > 1) ? $clog2(Depth) : 1;

    typedef enum logic [1:0] {RUN, PUSH, POP, REDIR} state_t;

    state_t               state;
    logic [PrioWidth-1:0] prio [NumIrq];
    logic [NumIrq-1:0]    pending;
    logic [31:0]          stack_pc [Depth];
    logic [PrioWidth-1:0] stack_prio [Depth];
    logic [DepW-1:0]      depth;
    logic [PrioWidth-1:0] cur_prio;
    logic [IdxW-1:0]      sel_idx;
    logic                 exit_redir;
    logic [31:0]          target;
    logic                 stall, push, pop, redirect, err;

    logic                 cand_found;
    logic [IdxW-1:0]      cand_idx;
    logic [PrioWidth-1:0] cand_prio;
    logic                 can_enter;
    logic [DepW-1:0]      depth_dec;
    logic [StkW-1:0]      push_ptr, pop_ptr;

    // A request raised this cycle already counts, so entry costs two cycles.
    // Strict compare keeps the lowest index on equal priorities.
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        cand_prio  = cur_prio;
        for (int i = 0; i < NumIrq; i++) begin
            if ((pending[i] || irq_i[i]) && prio[i] > cand_prio) begin
                cand_found = 1'b1;
                cand_idx   = IdxW'(i);
                cand_prio  = prio[i];
            end
        end
    end

    assign can_enter = cand_found && (depth < DepW'(Depth));
    assign depth_dec = depth - DepW'(1);
    assign push_ptr  = depth[StkW-1:0];
    assign pop_ptr   = depth_dec[StkW-1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= RUN;
            pending    <= '0;
            depth      <= '0;
            cur_prio   <= '0;
            sel_idx    <= '0;
            exit_redir <= 1'b0;
            target     <= '0;
            stall      <= 1'b0;
            push       <= 1'b0;
            pop        <= 1'b0;
            redirect   <= 1'b0;
            err        <= 1'b0;
            for (int i = 0; i < NumIrq; i++) prio[i] <= '0;
            for (int i = 0; i < Depth; i++) begin
                stack_pc[i]   <= '0;
                stack_prio[i] <= '0;
            end
        end else begin
            stall    <= 1'b0;
            push     <= 1'b0;
            pop      <= 1'b0;
            redirect <= 1'b0;
            err      <= 1'b0;
            pending  <= pending | irq_i;
            if (prio_we_i) prio[prio_idx_i] <= prio_data_i;

            case (state)
                RUN: begin
                    if (mret_i) begin
                        if (depth != '0) begin
                            state <= POP;
                            pop   <= 1'b1;
                            stall <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (can_enter) begin
                        sel_idx <= cand_idx;
                        state   <= PUSH;
                        push    <= 1'b1;
                        stall   <= 1'b1;
                    end
                end
                PUSH: begin
                    stack_pc[push_ptr]   <= pc_next_i;
                    stack_prio[push_ptr] <= cur_prio;
                    cur_prio             <= prio[sel_idx];
                    pending[sel_idx]     <= irq_i[sel_idx];
                    depth                <= depth + DepW'(1);
                    target               <= vec_base_i + (32'(sel_idx) << 2);
                    exit_redir           <= 1'b0;
                    redirect             <= 1'b1;
                    state                <= REDIR;
                end
                POP: begin
                    cur_prio   <= stack_prio[pop_ptr];
                    target     <= stack_pc[pop_ptr];
                    depth      <= depth_dec;
                    exit_redir <= 1'b1;
                    redirect   <= 1'b1;
                    state      <= REDIR;
                end
                REDIR: begin
                    // After an exit, a waiting line tail-chains without an idle RUN cycle.
                    exit_redir <= 1'b0;
                    if (exit_redir && can_enter) begin
                        sel_idx <= cand_idx;
                        state   <= PUSH;
                        push    <= 1'b1;
                        stall   <= 1'b1;
                    end else begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign stall_o    = stall & ~rst_i;
    assign push_o     = push & ~rst_i;
    assign pop_o      = pop & ~rst_i;
    assign redirect_o = redirect & ~rst_i;
    assign err_o      = err & ~rst_i;
    assign target_o   = rst_i ? '0 : target;
    assign depth_o    = rst_i ? '0 : depth;
    assign cur_prio_o = rst_i ? '0 : cur_prio;

endmodule

// File: tb/tb_hippo_irq_sched.sv
// Self-checking bench for hippo_irq_sched: vector table, directed nesting
// sequences and a randomized run against a stack-based reference model.
module tb_hippo_irq_sched;

    logic        clk;
    logic        rst_i;
    logic [7:0]  irq_i;
    logic        prio_we_i;
    logic [2:0]  prio_idx_i;
    logic [2:0]  prio_data_i;
    logic [31:0] vec_base_i;
    logic [31:0] pc_next_i;
    logic        mret_i;
    logic        stall_o, push_o, pop_o, redirect_o, err_o;
    logic [31:0] target_o;
    logic [2:0]  depth_o;
    logic [2:0]  cur_prio_o;

    int total = 0;
    int bad   = 0;
    logic [31:0] base;

    hippo_irq_sched #(.NumIrq(8), .PrioWidth(3), .Depth(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .irq_i(irq_i),
        .prio_we_i(prio_we_i), .prio_idx_i(prio_idx_i), .prio_data_i(prio_data_i),
        .vec_base_i(vec_base_i), .pc_next_i(pc_next_i), .mret_i(mret_i),
        .stall_o(stall_o), .push_o(push_o), .pop_o(pop_o),
        .redirect_o(redirect_o), .target_o(target_o),
        .depth_o(depth_o), .cur_prio_o(cur_prio_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct {
        logic        rst;
        logic [7:0]  irq;
        logic        we;
        logic [2:0]  idx;
        logic [2:0]  data;
        logic        mret;
        logic [31:0] pc;
        logic [4:0]  flags;   // {stall, push, pop, redirect, err}
        logic [31:0] target;
        logic [2:0]  depth;
        logic [2:0]  cur;
    } vec_t;

    vec_t tbl [25];

    // Reference model: a queue as the nesting stack plus a two-step
    // countdown for the stall/redirect phases of each transaction.
    typedef struct {
        logic [31:0] pc;
        int          prio;
    } frame_t;

    frame_t      stk [$];
    int          m_prio [8];
    logic [7:0]  m_pend;
    int          m_cur;
    int          m_wait;
    bit          m_entry;
    bit          m_after_exit;
    int          m_line;
    bit          e_stall, e_push, e_pop, e_redir, e_err;
    logic [31:0] e_target;

    function automatic logic [63:0] dut_pack();
        return 64'({stall_o, push_o, pop_o, redirect_o, err_o, depth_o, cur_prio_o, target_o});
    endfunction

    function automatic logic [63:0] model_pack();
        return 64'({e_stall, e_push, e_pop, e_redir, e_err, 3'(stk.size()), 3'(m_cur), e_target});
    endfunction

    function automatic int model_pick(logic [7:0] eff);
        for (int p = 7; p > m_cur; p--)
            for (int i = 0; i < 8; i++)
                if (eff[i] && m_prio[i] == p) return i;
        return -1;
    endfunction

    task automatic model_reset();
        stk.delete();
        for (int i = 0; i < 8; i++) m_prio[i] = 0;
        m_pend = '0; m_cur = 0; m_wait = 0; m_entry = 0; m_after_exit = 0; m_line = 0;
        e_stall = 0; e_push = 0; e_pop = 0; e_redir = 0; e_err = 0; e_target = '0;
    endtask

    task automatic model_start_entry(int cand);
        m_wait = 2; m_entry = 1; m_line = cand; e_push = 1; e_stall = 1;
    endtask

    task automatic model_step(bit rst, logic [7:0] irq, bit we, logic [2:0] idx,
                              logic [2:0] data, bit mret, logic [31:0] pc, logic [31:0] vec);
        int     cand;
        frame_t f;
        if (rst) begin
            model_reset();
            return;
        end
        cand = model_pick(m_pend | irq);
        m_pend = m_pend | irq;
        e_stall = 0; e_push = 0; e_pop = 0; e_redir = 0; e_err = 0;
        case (m_wait)
            0: begin
                if (mret) begin
                    if (stk.size() > 0) begin
                        m_wait = 2; m_entry = 0; e_pop = 1; e_stall = 1;
                    end else begin
                        e_err = 1;
                    end
                end else if (cand >= 0 && stk.size() < 4) begin
                    model_start_entry(cand);
                end
            end
            2: begin
                if (m_entry) begin
                    f.pc = pc; f.prio = m_cur;
                    stk.push_back(f);
                    m_cur = m_prio[m_line];
                    m_pend[m_line] = irq[m_line];
                    e_target = vec + 32'(m_line * 4);
                end else begin
                    f = stk.pop_back();
                    m_cur = f.prio;
                    e_target = f.pc;
                end
                m_after_exit = !m_entry;
                m_wait = 1;
                e_redir = 1;
            end
            default: begin
                m_wait = 0;
                if (m_after_exit && cand >= 0 && stk.size() < 4) model_start_entry(cand);
            end
        endcase
        if (we) m_prio[idx] = int'(data);
    endtask

    task automatic applyStimulus(input bit rst, input logic [7:0] irq, input bit we,
                                 input logic [2:0] idx, input logic [2:0] data,
                                 input bit mret, input logic [31:0] pc, input logic [31:0] vec);
        @(posedge clk);
        #1;
        rst_i = rst; irq_i = irq; prio_we_i = we; prio_idx_i = idx;
        prio_data_i = data; mret_i = mret; pc_next_i = pc; vec_base_i = vec;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic [7:0] irq, input bit mret, input logic [31:0] pc);
        applyStimulus(1'b0, irq, 1'b0, 3'd0, 3'd0, mret, pc, base);
    endtask

    task automatic write_prio(input logic [2:0] idx, input logic [2:0] data);
        applyStimulus(1'b0, 8'h00, 1'b1, idx, data, 1'b0, 32'h0, base);
    endtask

    task automatic do_reset();
        applyStimulus(1'b1, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0, 32'h0, base);
        step(8'h00, 1'b0, 32'h0);
    endtask

    task automatic chain_in(input string name, input logic [31:0] pc, input logic [31:0] tgt,
                            input logic [2:0] dep, input logic [2:0] cur);
        step(8'h00, 1'b0, pc);
        checkOutput({name, "_push"}, 64'({push_o, stall_o, pop_o, redirect_o}), 64'(4'b1100));
        step(8'h00, 1'b0, pc);
        checkOutput({name, "_redir"}, 64'({redirect_o, push_o, stall_o, target_o, depth_o, cur_prio_o}),
                    64'({3'b100, tgt, dep, cur}));
    endtask

    task automatic enter(input string name, input logic [7:0] mask, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic [2:0] dep, input logic [2:0] cur);
        step(mask, 1'b0, pc);
        chain_in(name, pc, tgt, dep, cur);
    endtask

    task automatic exit_level(input string name, input logic [31:0] tgt,
                              input logic [2:0] dep, input logic [2:0] cur);
        step(8'h00, 1'b1, 32'h0);
        step(8'h00, 1'b0, 32'h0);
        checkOutput({name, "_pop"}, 64'({pop_o, stall_o, push_o, redirect_o}), 64'(4'b1100));
        step(8'h00, 1'b0, 32'h0);
        checkOutput({name, "_redir"}, 64'({redirect_o, pop_o, stall_o, target_o, depth_o, cur_prio_o}),
                    64'({3'b100, tgt, dep, cur}));
    endtask

    initial begin
        logic any;
        bit          r_rst, r_we, r_mret;
        logic [7:0]  r_irq;
        logic [2:0]  r_idx, r_data;
        logic [31:0] r_pc;

        rst_i = 1'b1; irq_i = '0; prio_we_i = 1'b0; prio_idx_i = '0; prio_data_i = '0;
        mret_i = 1'b0; pc_next_i = '0; base = 32'h100; vec_base_i = base;

        // Basic entry/exit, mret at depth 0, mret racing a candidate, tail-chain.
        tbl[0]  = '{1'b1, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0, 32'h40, 5'b00000, 32'h000, 3'd0, 3'd0};
        tbl[1]  = '{1'b0, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0, 32'h40, 5'b00000, 32'h000, 3'd0, 3'd0};
        tbl[2]  = '{1'b0, 8'h00, 1'b1, 3'd2, 3'd3, 1'b0, 32'h40, 5'b00000, 32'h000, 3'd0, 3'd0};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 3'd5, 3'd6, 1'b0, 32'h40, 5'b00000, 32'h000, 3'd0, 3'd0};
        tbl[4]  = '{1'b0, 8'h04, 1'b0, 3'd0, 3'd0, 1'b0, 32'h40, 5'b00000, 32'h000, 3'd0, 3'd0};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0, 32'h40, 5'b11000, 32'h000, 3'd0, 3'd0};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0, 32'h40, 5'b00010, 32'h108, 3'd1, 3'd3};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0, 32'h40, 5'b00000, 32'h108, 3'd1, 3'd3};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 3'd0, 3'd0, 1'b1, 32'h40, 5'b00000, 32'h108, 3'd1, 3'd3};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0, 32'h40, 5'b10100, 32'h108, 3'd1, 3'd3};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0, 32'h40, 5'b00010, 32'h040, 3'd0, 3'd0};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 3'd0, 3'd0, 1'b1, 32'h40, 5'b00000, 32'h040, 3'd0, 3'd0};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0, 32'h40, 5'b00001, 32'h040, 3'd0, 3'd0};
        tbl[13] = '{1'b0, 8'h04, 1'b0, 3'd0, 3'd0, 1'b0, 32'h40, 5'b00000, 32'h040, 3'd0, 3'd0};
        tbl[14] = '{1'b0, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0, 32'h40, 5'b11000, 32'h040, 3'd0, 3'd0};
        tbl[15] = '{1'b0, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0, 32'h40, 5'b00010, 32'h108, 3'd1, 3'd3};
        tbl[16] = '{1'b0, 8'h20, 1'b0, 3'd0, 3'd0, 1'b1, 32'h40, 5'b00000, 32'h108, 3'd1, 3'd3};
        tbl[17] = '{1'b0, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0, 32'h40, 5'b10100, 32'h108, 3'd1, 3'd3};
        tbl[18] = '{1'b0, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0, 32'h40, 5'b00010, 32'h040, 3'd0, 3'd0};
        tbl[19] = '{1'b0, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0, 32'h80, 5'b11000, 32'h040, 3'd0, 3'd0};
        tbl[20] = '{1'b0, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0, 32'h80, 5'b00010, 32'h114, 3'd1, 3'd6};
        tbl[21] = '{1'b0, 8'h00, 1'b0, 3'd0, 3'd0, 1'b1, 32'h80, 5'b00000, 32'h114, 3'd1, 3'd6};
        tbl[22] = '{1'b0, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0, 32'h80, 5'b10100, 32'h114, 3'd1, 3'd6};
        tbl[23] = '{1'b0, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0, 32'h80, 5'b00010, 32'h080, 3'd0, 3'd0};
        tbl[24] = '{1'b0, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0, 32'h80, 5'b00000, 32'h080, 3'd0, 3'd0};

        for (int i = 0; i < 25; i++) begin
            applyStimulus(tbl[i].rst, tbl[i].irq, tbl[i].we, tbl[i].idx, tbl[i].data,
                          tbl[i].mret, tbl[i].pc, base);
            checkOutput($sformatf("vec%0d", i), dut_pack(),
                        64'({tbl[i].flags, tbl[i].depth, tbl[i].cur, tbl[i].target}));
        end

        // Nested preemption: line 5 preempts line 1, line 0 waits until level 0.
        base = 32'h200;
        do_reset();
        write_prio(3'd1, 3'd2);
        write_prio(3'd5, 3'd6);
        write_prio(3'd0, 3'd1);
        enter("nest_l1", 8'h02, 32'h500, 32'h204, 3'd1, 3'd2);
        enter("nest_l5", 8'h21, 32'h504, 32'h214, 3'd2, 3'd6);
        any = 1'b0;
        repeat (4) begin step(8'h00, 1'b0, 32'h0); any |= push_o; end
        checkOutput("nest_l0_held", 64'(any), 64'(0));
        exit_level("nest_x5", 32'h504, 3'd1, 3'd2);
        any = 1'b0;
        repeat (3) begin step(8'h00, 1'b0, 32'h0); any |= push_o; end
        checkOutput("nest_l0_held2", 64'(any), 64'(0));
        exit_level("nest_x1", 32'h500, 3'd0, 3'd0);
        chain_in("nest_l0", 32'h508, 32'h200, 3'd1, 3'd1);
        exit_level("nest_x0", 32'h508, 3'd0, 3'd0);

        // Full stack blocks a higher line; equal-priority lines 3 and 6 resolve by index.
        base = 32'h300;
        do_reset();
        write_prio(3'd0, 3'd1);
        write_prio(3'd1, 3'd2);
        write_prio(3'd2, 3'd3);
        write_prio(3'd4, 3'd5);
        write_prio(3'd7, 3'd7);
        write_prio(3'd3, 3'd4);
        write_prio(3'd6, 3'd4);
        enter("full_e0", 8'h01, 32'hA0, 32'h300, 3'd1, 3'd1);
        enter("full_e1", 8'h02, 32'hA4, 32'h304, 3'd2, 3'd2);
        enter("full_e2", 8'h04, 32'hA8, 32'h308, 3'd3, 3'd3);
        enter("full_e4", 8'h10, 32'hAC, 32'h310, 3'd4, 3'd5);
        step(8'hC8, 1'b0, 32'h0);
        any = push_o;
        repeat (4) begin step(8'h00, 1'b0, 32'h0); any |= push_o; end
        checkOutput("full_no_push", 64'({any, depth_o}), 64'({1'b0, 3'd4}));
        exit_level("full_x4", 32'hAC, 3'd3, 3'd3);
        chain_in("full_e7", 32'hB0, 32'h31C, 3'd4, 3'd7);
        exit_level("full_x7", 32'hB0, 3'd3, 3'd3);
        chain_in("full_tie3", 32'hB4, 32'h30C, 3'd4, 3'd4);
        exit_level("full_x3", 32'hB4, 3'd3, 3'd3);
        chain_in("full_tie6", 32'hB8, 32'h318, 3'd4, 3'd4);

        // Reset while the FSM is in PUSH for line 2.
        base = 32'h100;
        do_reset();
        write_prio(3'd2, 3'd3);
        step(8'h04, 1'b0, 32'h40);
        applyStimulus(1'b1, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0, 32'h40, base);
        step(8'h00, 1'b0, 32'h40);
        checkOutput("rst_push_after", dut_pack(), 64'(0));
        write_prio(3'd2, 3'd3);
        any = 1'b0;
        repeat (5) begin step(8'h00, 1'b0, 32'h40); any |= push_o | redirect_o | stall_o; end
        checkOutput("rst_push_pending", 64'({any, depth_o}), 64'(0));

        // Randomized run against the reference model, with occasional resets.
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            r_rst  = (c == 0) || ($urandom_range(0, 399) == 0);
            r_irq  = 8'($urandom & $urandom & $urandom);
            r_we   = ($urandom_range(0, 3) == 0);
            r_idx  = 3'($urandom);
            r_data = 3'($urandom);
            r_mret = ($urandom_range(0, 5) == 0);
            r_pc   = $urandom;
            if (c % 250 == 0) base = (c % 500 == 0) ? 32'hFFFF_FFF0 : $urandom;
            applyStimulus(r_rst, r_irq, r_we, r_idx, r_data, r_mret, r_pc, base);
            checkOutput($sformatf("rand%0d", c), dut_pack(), r_rst ? 64'(0) : model_pack());
            model_step(r_rst, r_irq, r_we, r_idx, r_data, r_mret, r_pc, base);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hippo_irq_sched.md
HIPPO_IRQ_SCHED -- requirements
Module: hippo_irq_sched

Interface
REQ-001 SHALL have parameter NumIrq, default 8, the number of interrupt lines.
REQ-002 SHALL have parameter PrioWidth, default 3, the priority field width; priority 0 means disabled.
REQ-003 SHALL have parameter Depth, default 4, the maximum nesting depth; it equals the RegFileStack Depth.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_i, input, 1 bit: synchronous active-high reset, sampled on the rising edge of clk_i.
REQ-006 SHALL have port irq_i, input, NumIrq bits: level interrupt requests.
REQ-007 SHALL have ports prio_we_i (1 bit), prio_idx_i ($clog2(NumIrq) bits) and prio_data_i (PrioWidth bits), all inputs: priority configuration write.
REQ-008 SHALL have port vec_base_i, input, 32 bits: vector table base address.
REQ-009 SHALL have port pc_next_i, input, 32 bits: the core's next PC, used as the return address.
REQ-010 SHALL have port mret_i, input, 1 bit: the core is retiring a return-from-interrupt this cycle.
REQ-011 SHALL have port stall_o, output, 1 bit: hold the core PC and suppress register-file writes.
REQ-012 SHALL have ports push_o and pop_o, outputs, 1 bit each: RegFileStack command (both low means none).
REQ-013 SHALL have ports redirect_o (1 bit) and target_o (32 bits), outputs: PC override.
REQ-014 SHALL have ports depth_o ($clog2(Depth+1) bits) and cur_prio_o (PrioWidth bits), outputs: nesting status.
REQ-015 SHALL have port err_o, output, 1 bit: a one-cycle pulse on mret_i at depth 0.

Function
REQ-016 SHALL hold per-line registers prio[NumIrq] and pending[NumIrq]; a pending bit sets on any cycle its irq_i is 1.
REQ-017 SHALL, on prio_we_i, write prio[prio_idx_i] at the clock edge; arbitration sees the new value from the next cycle.
REQ-018 SHALL define a candidate as a pending line whose prio is greater than cur_prio_o; the candidate chosen is the highest prio, with ties going to the lowest index.
REQ-019 SHALL implement the FSM states RUN, PUSH, POP and REDIR.
REQ-020 SHALL, in RUN with mret_i=1 and depth>0, go to POP; mret_i has precedence over any candidate in the same cycle.
REQ-021 SHALL, in RUN with mret_i=1 and depth=0, pulse err_o and stay in RUN.
REQ-022 SHALL, in RUN with no mret_i, a candidate present and depth<Depth, latch the candidate index and go to PUSH.
REQ-023 SHALL, in RUN with depth=Depth, take no new entry and keep pending bits set.
REQ-024 SHALL, in PUSH:
- assert push_o=1 and stall_o=1;
- push {pc_next_i, cur_prio} onto an internal stack of Depth entries;
- set cur_prio to the latched line's prio;
- clear that line's pending bit, unless irq_i for that line is still 1;
- increment depth;
- set target to vec_base_i + 4*index;
- go to REDIR.
REQ-025 SHALL, in POP:
- assert pop_o=1 and stall_o=1;
- pop the top entry, restoring cur_prio and setting target to the saved PC;
- decrement depth;
- go to REDIR.
REQ-026 SHALL, in REDIR, assert redirect_o=1 with target_o valid, keep stall_o=0, and go to RUN.
REQ-027 SHALL give an entry latency of 2 cycles: a candidate present in RUN at cycle T gives push_o at T+1 and redirect_o at T+2.
REQ-028 SHALL give an exit latency of 2 cycles: mret_i at T gives pop_o at T+1 and redirect_o at T+2.
REQ-029 SHALL ignore mret_i outside RUN.
REQ-030 SHALL never assert push_o and pop_o together.
REQ-031 SHALL compute target_o in 32-bit arithmetic, wrapping modulo 2^32.
REQ-032 SHALL NOT let priority writes alter any stacked priority.
REQ-033 SHALL, after an exit returns to RUN, re-evaluate candidates immediately, so a tail-chained entry's push_o comes 1 cycle after the exit's redirect_o.

Reset
REQ-034 SHALL, on rst_i=1 at a clock edge, in any state including mid-PUSH or mid-POP:
- clear all pending bits, all prio registers, the stack and depth;
- set cur_prio to 0 and the FSM to RUN.
REQ-035 SHALL hold every output at 0 during reset and in the cycle after it: stall_o, push_o, pop_o, redirect_o, target_o, depth_o, cur_prio_o and err_o.

Verification
REQ-036 SHALL cover a basic entry and exit:
- stimulus: prio[2]=3, vec_base=0x100, pc_next=0x40, irq_i[2] pulsed at T; then mret_i later;
- response: push_o at T+1, then redirect_o with target 0x108 at T+2, depth 1, cur_prio 3; mret_i gives pop_o, then redirect_o with target 0x40, depth 0.
REQ-037 SHALL cover nested preemption:
- stimulus: line 1 active at prio 2; line 5 raised at prio 6; line 0 raised at prio 1;
- response: line 5 enters (depth 2, target base+0x14); line 0 stays pending until cur_prio falls below 1.
REQ-038 SHALL cover full and priority ties:
- stimulus: Depth=4 entries active; a fifth, higher-priority line pends; then lines 3 and 6 pend with equal prio 4;
- response: no push_o at depth 4, and entry follows the next exit; of the tied pair, line 3 is taken first.
REQ-039 SHALL cover mret_i and a candidate in the same cycle, and mret_i at depth 0:
- simultaneous: pop_o first, then push_o one cycle after the exit's redirect_o;
- mret_i at depth 0: an err_o pulse and no pop_o.
REQ-040 SHALL cover reset during PUSH: all outputs are 0 the next cycle, depth 0, and line 2 no longer pending.
